ser5_rx: RTL and testbench

Serial-to-parallel front end for the 5-bit data path. It receives an asynchronous-style serial frame (start bit, 5 data bits LSB-first, optional parity bit, stop bit), sampled only on a bit-rate enable tick. It presents the assembled word on a 5-bit bus with a valid/acknowledge handshake. It sits directly upstream of the 5-bit holding register: `Dout` drives the register's data input, and `Valid` qualifies when that data is meaningful.

---
 rtl/ser5_pkg.sv | 15 +
 rtl/ser5_shift.sv | 49 ++++
 rtl/ser5_rx.sv | 134 +++++++++++++
 tb/tb_ser5_rx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser5_pkg.sv
// Shared state encoding and sizing constants for the 5-bit serial receiver.
package ser5_pkg;

  localparam int SER5_WIDTH = 5;
  localparam int SER5_CNT_W = $clog2(SER5_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAR  = 3'd2,
    STOP = 3'd3,
    HOLD = 3'd4
  } ser5_state_e;

endpackage

// File: rtl/ser5_shift.sv
// Data shift register and bit counter for ser5_rx.
// Bits enter at the MSB and shift right, so the first bit received ends up at bit 0.
module ser5_shift
  import ser5_pkg::*;
#(
  parameter int WIDTH = SER5_WIDTH
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Clr,
  input  logic             ShiftEn,
  input  logic             SerIn,
  output logic [WIDTH-1:0] Data,
  output logic             Done
);

  localparam int CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (Clr) begin
      count_d = '0;
    end else if (ShiftEn) begin
      shift_d = {SerIn, shift_q[WIDTH-1:1]};
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // Done flags the shift that is taking in the last data bit of the frame.
  assign Done = ShiftEn && (count_q == CntW'(WIDTH - 1));
  assign Data = shift_q;

endmodule

// File: rtl/ser5_rx.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Define SER5_RX_PARITY_EN to build the variant whose frames carry a parity bit.
module ser5_rx
  import ser5_pkg::*;
#(
  parameter int WIDTH = SER5_WIDTH
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             BitEn,
  input  logic             SerIn,
  input  logic             Ack,
  output logic [WIDTH-1:0] Dout,
  output logic             Valid,
  output logic             Busy,
  output logic             FrameErr,
  output logic             ParErr,
  output logic             Overrun
);

`ifdef SER5_RX_PARITY_EN
  localparam ser5_state_e AfterData = PAR;
`else
  localparam ser5_state_e AfterData = STOP;
`endif

  ser5_state_e      state_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             frameErr_q;
  logic             overrun_q;
`ifdef SER5_RX_PARITY_EN
  logic             parErr_q;
`endif

  logic [WIDTH-1:0] shiftData;
  logic             shiftDone;
  logic             shiftEn;
  logic             shiftClr;

  assign shiftEn  = BitEn && (state_q == DATA);
  assign shiftClr = BitEn && (state_q == IDLE) && !SerIn;

  ser5_shift #(
    .WIDTH(WIDTH)
  ) uShift (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Clr    (shiftClr),
    .ShiftEn(shiftEn),
    .SerIn  (SerIn),
    .Data   (shiftData),
    .Done   (shiftDone)
  );

  // In HOLD an Ack takes priority over a start bit, so that tick is neither a start nor an overrun.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SER5_RX_PARITY_EN
      parErr_q   <= 1'b0;
`endif
    end else begin
      frameErr_q <= 1'b0;
`ifdef SER5_RX_PARITY_EN
      parErr_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (BitEn && !SerIn) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (shiftDone) begin
            state_q <= AfterData;
          end
        end
`ifdef SER5_RX_PARITY_EN
        PAR: begin
          if (BitEn) begin
            if (SerIn != ^shiftData) begin
              parErr_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              state_q  <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (BitEn) begin
            if (SerIn) begin
              dout_q  <= shiftData;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        HOLD: begin
          if (Ack) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
          end else if (BitEn && !SerIn) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy     = (state_q == DATA) || (state_q == PAR) || (state_q == STOP);
  assign Dout     = dout_q;
  assign Valid    = valid_q;
  assign FrameErr = frameErr_q;
  assign Overrun  = overrun_q;
`ifdef SER5_RX_PARITY_EN
  assign ParErr   = parErr_q;
`else
  assign ParErr   = 1'b0;
`endif

endmodule

// File: tb/tb_ser5_rx.sv
// Bench for ser5_rx: a directed vector table, hand-written corner sequences, and random traffic
// checked every cycle against a frame-level model. Define SER5_RX_PARITY_EN for the parity variant.
module tb_ser5_rx;

  localparam int W = 5;
`ifdef SER5_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic         Clk = 1'b0;
  logic         Resetn;
  logic         BitEn;
  logic         SerIn;
  logic         Ack;
  logic [W-1:0] Dout;
  logic         Valid;
  logic         Busy;
  logic         FrameErr;
  logic         ParErr;
  logic         Overrun;

  always #5 Clk = ~Clk;

  ser5_rx #(
    .WIDTH(W)
  ) dut (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .BitEn   (BitEn),
    .SerIn   (SerIn),
    .Ack     (Ack),
    .Dout    (Dout),
    .Valid   (Valid),
    .Busy    (Busy),
    .FrameErr(FrameErr),
    .ParErr  (ParErr),
    .Overrun (Overrun)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Frame-level model: the bits sampled since the start bit, plus the presented word and flags.
  logic         frameBits[$];
  logic [W-1:0] expDout;
  logic         expValid;
  logic         expOvr;
  logic         expFerr;
  logic         expPerr;

  // stim = {BitEn, SerIn, Ack}; flags = {Valid, Busy, FrameErr, ParErr, Overrun}
  typedef struct {
    logic [2:0]   stim;
    int           gap;
    logic [W-1:0] dout;
    logic [4:0]   flags;
  } vec_t;

  vec_t vecs[$];

  task automatic modelReset();
    frameBits.delete();
    expDout  = '0;
    expValid = 1'b0;
    expOvr   = 1'b0;
    expFerr  = 1'b0;
    expPerr  = 1'b0;
  endtask

  function automatic logic [W-1:0] frameData();
    logic [W-1:0] d;
    d = '0;
    for (int i = 0; i < W; i++) d[i] = frameBits[i + 1];
    return d;
  endfunction

  task automatic modelStep(input logic be, input logic si, input logic ak);
    expFerr = 1'b0;
    expPerr = 1'b0;
    if (expValid) begin
      if (ak) begin
        expValid = 1'b0;
        expOvr   = 1'b0;
      end else if (be && !si) begin
        expOvr = 1'b1;
      end
    end else if (be) begin
      if (frameBits.size() == 0) begin
        if (!si) frameBits.push_back(si);
      end else begin
        frameBits.push_back(si);
        if (PAR_BITS == 1 && frameBits.size() == W + 2) begin
          if (si != ^frameData()) begin
            expPerr = 1'b1;
            frameBits.delete();
          end
        end else if (frameBits.size() == W + 2 + PAR_BITS) begin
          if (si) begin
            expDout  = frameData();
            expValid = 1'b1;
          end else begin
            expFerr = 1'b1;
          end
          frameBits.delete();
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("model Dout", int'(Dout), int'(expDout));
    checkOutput("model Valid", int'(Valid), int'(expValid));
    checkOutput("model Busy", int'(Busy), int'(frameBits.size() != 0));
    checkOutput("model FrameErr", int'(FrameErr), int'(expFerr));
    checkOutput("model ParErr", int'(ParErr), int'(expPerr));
    checkOutput("model Overrun", int'(Overrun), int'(expOvr));
  endtask

  task automatic applyStimulus(input logic be, input logic si, input logic ak);
    BitEn = be;
    SerIn = si;
    Ack   = ak;
    @(posedge Clk);
    modelStep(be, si, ak);
    #1;
    checkModel();
  endtask

  task automatic addRow(input logic [2:0] stim, input int gap, input logic [W-1:0] dout,
                        input logic [4:0] flags);
    vec_t v;
    v.stim  = stim;
    v.gap   = gap;
    v.dout  = dout;
    v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic addFrameHead(input logic [W-1:0] data, input logic [W-1:0] doutNow);
    addRow(3'b100, 3, doutNow, 5'b01000);
    for (int i = 0; i < W; i++) addRow({1'b1, data[i], 1'b0}, 3, doutNow, 5'b01000);
  endtask

  task automatic idleGap(input int minGap, input int maxGap);
    repeat ($urandom_range(maxGap, minGap)) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("gap Busy", int'(Busy), 1);
    end
  endtask

  task automatic sendFrame(input logic [W-1:0] data, input logic parOk, input logic stopBit,
                           input int minGap, input int maxGap);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start Busy", int'(Busy), 1);
    idleGap(minGap, maxGap);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b1, data[i], 1'b0);
      checkOutput("data Busy", int'(Busy), 1);
      idleGap(minGap, maxGap);
    end
`ifdef SER5_RX_PARITY_EN
    applyStimulus(1'b1, (^data) ^ ~parOk, 1'b0);
    if (parOk) begin
      checkOutput("parity Busy", int'(Busy), 1);
      idleGap(minGap, maxGap);
    end else begin
      checkOutput("parity ParErr", int'(ParErr), 1);
    end
    if (parOk) applyStimulus(1'b1, stopBit, 1'b0);
`else
    applyStimulus(1'b1, stopBit, 1'b0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] rd;
    logic         pOk;
    logic         sOk;

    Resetn = 1'b0;
    BitEn  = 1'b0;
    SerIn  = 1'b1;
    Ack    = 1'b0;
    modelReset();
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset Dout", int'(Dout), 0);
    checkOutput("reset Valid", int'(Valid), 0);
    checkOutput("reset Busy", int'(Busy), 0);
    checkOutput("reset FrameErr", int'(FrameErr), 0);
    checkOutput("reset ParErr", int'(ParErr), 0);
    checkOutput("reset Overrun", int'(Overrun), 0);
    #4;
    Resetn = 1'b1;

    // Bad stop bit first, so Dout must still read 0 afterwards.
    addFrameHead(5'h16, 5'h00);
`ifdef SER5_RX_PARITY_EN
    addRow(3'b110, 3, 5'h00, 5'b01000);
`endif
    addRow(3'b100, 0, 5'h00, 5'b00100);
    addRow(3'b010, 3, 5'h00, 5'b00000);
`ifdef SER5_RX_PARITY_EN
    addFrameHead(5'h16, 5'h00);
    addRow(3'b100, 0, 5'h00, 5'b00010);
    addRow(3'b010, 3, 5'h00, 5'b00000);
`endif
    addFrameHead(5'h16, 5'h00);
`ifdef SER5_RX_PARITY_EN
    addRow(3'b110, 3, 5'h00, 5'b01000);
`endif
    addRow(3'b110, 0, 5'h16, 5'b10000);
    addRow(3'b100, 3, 5'h16, 5'b10001);
    addRow(3'b110, 3, 5'h16, 5'b10001);
    addRow(3'b011, 0, 5'h16, 5'b00000);
    addRow(3'b011, 0, 5'h16, 5'b00000);
    addRow(3'b010, 0, 5'h16, 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim[2], vecs[i].stim[1], vecs[i].stim[0]);
      checkOutput($sformatf("vec%0d Dout", i), int'(Dout), int'(vecs[i].dout));
      checkOutput($sformatf("vec%0d Valid", i), int'(Valid), int'(vecs[i].flags[4]));
      checkOutput($sformatf("vec%0d Busy", i), int'(Busy), int'(vecs[i].flags[3]));
      checkOutput($sformatf("vec%0d FrameErr", i), int'(FrameErr), int'(vecs[i].flags[2]));
      checkOutput($sformatf("vec%0d ParErr", i), int'(ParErr), int'(vecs[i].flags[1]));
      checkOutput($sformatf("vec%0d Overrun", i), int'(Overrun), int'(vecs[i].flags[0]));
      repeat (vecs[i].gap) applyStimulus(1'b0, 1'b1, 1'b0);
    end

    // Reset in the middle of a frame, then a clean frame 5'h09.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    BitEn  = 1'b0;
    SerIn  = 1'b1;
    Ack    = 1'b0;
    Resetn = 1'b0;
    #2;
    modelReset();
    checkOutput("midrst Dout", int'(Dout), 0);
    checkOutput("midrst Valid", int'(Valid), 0);
    checkOutput("midrst Busy", int'(Busy), 0);
    checkOutput("midrst FrameErr", int'(FrameErr), 0);
    checkOutput("midrst ParErr", int'(ParErr), 0);
    checkOutput("midrst Overrun", int'(Overrun), 0);
    @(posedge Clk);
    #1;
    Resetn = 1'b1;
    sendFrame(5'h09, 1'b1, 1'b1, 1, 3);
    checkOutput("rx09 Dout", int'(Dout), 9);
    checkOutput("rx09 Valid", int'(Valid), 1);
    checkOutput("rx09 FrameErr", int'(FrameErr), 0);
    checkOutput("rx09 ParErr", int'(ParErr), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rx09 ack Valid", int'(Valid), 0);

    // Irregular gaps, then Ack colliding with a start bit in HOLD.
    sendFrame(5'h1F, 1'b1, 1'b1, 1, 7);
    checkOutput("rx1F Dout", int'(Dout), 31);
    checkOutput("rx1F Valid", int'(Valid), 1);
    checkOutput("rx1F Busy", int'(Busy), 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ackwin Valid", int'(Valid), 0);
    checkOutput("ackwin Overrun", int'(Overrun), 0);
    checkOutput("ackwin Busy", int'(Busy), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ackwin idle Busy", int'(Busy), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ackwin tick Busy", int'(Busy), 0);

    // Random well-formed frames with occasional parity/stop faults and overruns.
    for (int n = 0; n < 40; n++) begin
      rd  = W'($urandom_range(0, 31));
      pOk = ($urandom_range(0, 3) != 0);
      sOk = ($urandom_range(0, 3) != 0);
      sendFrame(rd, pOk, sOk, 0, 3);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b1, 1'b0);
      if (expValid) begin
        if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
      end
    end

    // Unconstrained line noise against the model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
